exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception sequencer for the multicycle MIPS datapath, sitting directly upstream of the PC-source multiplexer. It detects invalid-opcode, overflow and divide-by-zero events and saves the faulting address into EPC. It then fetches the handler address byte from memory and drives the PC-source select and PC write for the jump. It also drives the EPC-return path for `eret`.

## Interface
Parameters:
- `MEM_LAT`, default 2: memory read latency in cycles, legal range 1–7.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `exc_opcode`: in, 1. Invalid-opcode event, one-cycle pulse.
- `exc_overflow`: in, 1. ALU overflow event.
- `exc_div0`: in, 1. Divide-by-zero event.
- `eret`: in, 1. Return-from-exception request.
- `pc_in`: in, 32. Current PC, already incremented by 4.
- `mem_data_in`: in, 32. Memory read data.
- `mem_addr`: out, 32. Vector byte address.
- `mem_read`: out, 1. Read strobe.
- `epc_out`: out, 32. EPC register, feeds the mux EPC input.
- `exc_vector`: out, 32. Zero-extended handler address, feeds the mux memory input.
- `pc_sel`: out, 3. PC-source select.
- `pc_write`: out, 1. PC load enable.
- `exc_busy`: out, 1. Sequencer active; main control stalls.
- `exc_cause`: out, 2. 0 = opcode, 1 = overflow, 2 = div0, 3 = none.

## Operation
- States: IDLE, FETCH, CAPTURE, JUMP, RET.
- IDLE, any enabled exception pulse:
  - Latch `exc_cause` by priority: opcode > overflow > div0.
  - `epc_out <= pc_in - 32'd4`, with 32-bit wrap: `pc_in = 0` gives `32'hFFFF_FFFC`.
  - Next state FETCH.
- IDLE, `eret` with no exception: next state RET. An exception wins over a simultaneous `eret`.
- FETCH:
  - `mem_addr` = 253 (opcode), 254 (overflow) or 255 (div0); `mem_read` = 1.
  - Stays MEM_LAT cycles, tracked by a down-counter, then goes to CAPTURE.
- CAPTURE: `exc_vector <= {24'b0, mem_data_in[7:0]}`; next state JUMP.
- JUMP: `pc_sel` = 3'b101, `pc_write` = 1; next state IDLE.
- RET: `pc_sel` = 3'b011, `pc_write` = 1; next state IDLE. EPC and cause are unchanged.
- Exception pulses and `eret` arriving outside IDLE are ignored; nothing is queued.
- Default outputs outside JUMP and RET: `pc_sel` = 3'b000, `pc_write` = 0, `mem_read` = 0, `mem_addr` = 0.

## Timing
- Reset values: `epc_out` = 0, `exc_vector` = 0, `exc_cause` = 3, `pc_sel` = 3'b000. All 1-bit outputs are 0, `mem_addr` = 0, state = IDLE, counter = 0.
- Reset asserted in any state: back to IDLE on the next edge, all registers cleared. A partially fetched vector is discarded.
- An exception sampled in cycle T:
  - EPC and cause are visible from T+1.
  - FETCH occupies T+1 to T+MEM_LAT.
  - CAPTURE is at T+MEM_LAT+1.
  - JUMP (`pc_write` high) is at T+MEM_LAT+2.
  - With MEM_LAT = 2, `pc_write` is at T+4.
- `exc_busy` is high from T+1 through JUMP inclusive, and low in IDLE and RET.
- `eret` sampled in cycle T: RET at T+1, one cycle of `pc_write`.
- `pc_write` is never high for more than one consecutive cycle.
- Outputs are registered state decodes; there is no combinational path from inputs to outputs.

## Configuration
- `EXC_DIV0_EN` defined: `exc_div0` is handled with cause 2 and vector address 255.
- `EXC_DIV0_EN` undefined: `exc_div0` is ignored, no divide-by-zero decode or vector-address logic is built, and cause 2 never appears.

## Structure
- Shared package `exc_pkg` holds:
  - state encoding enum;
  - cause codes;
  - vector addresses 253/254/255;
  - PC-select constants `PCSEL_PC4` = 3'b000, `PCSEL_EPC` = 3'b011, `PCSEL_MEM` = 3'b101.
- One sub-module, `exc_lat_counter`: a loadable down-counter of width $clog2(MEM_LAT+1) with a `done` flag, used by FETCH.

## Test plan
- Overflow with `pc_in` = 32'h0000_0104, memory[254] = 8'h3C, MEM_LAT = 2:
  - `epc_out` = 32'h0000_0100 at T+1;
  - `mem_addr` = 254 during T+1..T+2;
  - `exc_vector` = 32'h0000_003C, `pc_sel` = 3'b101 and `pc_write` = 1 at T+4;
  - `exc_cause` = 1.
- `exc_opcode`, `exc_overflow` and `exc_div0` asserted together: cause = 0, `mem_addr` = 253.
- `eret` in IDLE: one cycle later `pc_sel` = 3'b011, `pc_write` = 1; `exc_busy` stays 0; `epc_out` is unchanged.
- Overflow arriving during FETCH of an earlier opcode exception: ignored; exactly one JUMP; cause stays 0.
- `reset` pulsed in CAPTURE: next cycle everything is at reset values, no `pc_write`, and a following exception behaves normally.
- Build without `EXC_DIV0_EN`, `exc_div0` pulsed: stays in IDLE, `exc_busy` = 0, no `mem_read`.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
// EXC_DIV0_EN enables the divide-by-zero vector decode.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_JUMP,
    S_RET
  } state_t;

  localparam logic [1:0] CAUSE_OPC  = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_DIV0 = 2'd2;
  localparam logic [1:0] CAUSE_NONE = 2'd3;

  localparam logic [31:0] VEC_OPC  = 32'd253;
  localparam logic [31:0] VEC_OVF  = 32'd254;
  localparam logic [31:0] VEC_DIV0 = 32'd255;

  localparam logic [2:0] PCSEL_PC4 = 3'b000;
  localparam logic [2:0] PCSEL_EPC = 3'b011;
  localparam logic [2:0] PCSEL_MEM = 3'b101;

  function automatic logic [31:0] vec_addr(
    input logic [1:0] cause
  );
    logic [31:0] a;
    a = 32'd0;
    case (cause)
      CAUSE_OPC:  a = VEC_OPC;
      CAUSE_OVF:  a = VEC_OVF;
`ifdef EXC_DIV0_EN
      CAUSE_DIV0: a = VEC_DIV0;
`endif
      default:    a = 32'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/exc_lat_counter.sv
// Loadable down-counter timing the vector fetch.
// done is high once the count reaches zero.
module exc_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: saves EPC, fetches the handler byte, drives the PC jump.
// Define EXC_DIV0_EN to also handle exc_div0 (cause 2, vector 255).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic        eret,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [31:0] epc_out,
  output logic [31:0] exc_vector,
  output logic [2:0]  pc_sel,
  output logic        pc_write,
  output logic        exc_busy,
  output logic [1:0]  exc_cause
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  state_t      state_d, state_q;
  logic [31:0] epc_d, epc_q;
  logic [31:0] vec_d, vec_q;
  logic [1:0]  cause_d, cause_q;
  logic [31:0] mem_addr_d, mem_addr_q;
  logic        mem_read_d, mem_read_q;
  logic [2:0]  pc_sel_d, pc_sel_q;
  logic        pc_write_d, pc_write_q;
  logic        busy_d, busy_q;
  logic [1:0]  new_cause;
  logic        exc_any;
  logic        cnt_load, cnt_dec, cnt_done;

`ifdef EXC_DIV0_EN
  logic unused_in;
  assign unused_in = ^mem_data_in[31:8];
`else
  logic unused_in;
  assign unused_in = ^{mem_data_in[31:8], exc_div0};
`endif

  always_comb begin
    new_cause = CAUSE_NONE;
    priority case (1'b1)
      exc_opcode:   new_cause = CAUSE_OPC;
      exc_overflow: new_cause = CAUSE_OVF;
`ifdef EXC_DIV0_EN
      exc_div0:     new_cause = CAUSE_DIV0;
`endif
      default:      new_cause = CAUSE_NONE;
    endcase
  end

  assign exc_any = (new_cause != CAUSE_NONE);

  exc_lat_counter #(
    .W(CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    vec_d    = vec_q;
    cause_d  = cause_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exc_any) begin
          cause_d  = new_cause;
          epc_d    = pc_in - 32'd4;
          cnt_load = 1'b1;
          state_d  = S_FETCH;
        end else if (eret) begin
          state_d = S_RET;
        end
      end
      S_FETCH: begin
        if (cnt_done) state_d = S_CAPTURE;
        else          cnt_dec = 1'b1;
      end
      S_CAPTURE: begin
        vec_d   = {24'b0, mem_data_in[7:0]};
        state_d = S_JUMP;
      end
      S_JUMP:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    mem_read_d = (state_d == S_FETCH);
    mem_addr_d = mem_read_d ? vec_addr(cause_d) : 32'd0;
    pc_write_d = (state_d == S_JUMP) || (state_d == S_RET);
    busy_d     = (state_d == S_FETCH) || (state_d == S_CAPTURE)
              || (state_d == S_JUMP);
    pc_sel_d   = PCSEL_PC4;
    unique case (state_d)
      S_JUMP:  pc_sel_d = PCSEL_MEM;
      S_RET:   pc_sel_d = PCSEL_EPC;
      default: pc_sel_d = PCSEL_PC4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      epc_q      <= 32'd0;
      vec_q      <= 32'd0;
      cause_q    <= CAUSE_NONE;
      mem_addr_q <= 32'd0;
      mem_read_q <= 1'b0;
      pc_sel_q   <= PCSEL_PC4;
      pc_write_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      vec_q      <= vec_d;
      cause_q    <= cause_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      pc_sel_q   <= pc_sel_d;
      pc_write_q <= pc_write_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign epc_out    = epc_q;
  assign exc_vector = vec_q;
  assign pc_sel     = pc_sel_q;
  assign pc_write   = pc_write_q;
  assign exc_busy   = busy_q;
  assign exc_cause  = cause_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected jumps queued at stimulus,
// popped when pc_write is observed.
module tb_exc_ctrl;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] addr;
    logic [31:0] vec;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0;
  logic        exc_overflow = 1'b0;
  logic        exc_div0 = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] epc_out;
  logic [31:0] exc_vector;
  logic [2:0]  pc_sel;
  logic        pc_write;
  logic        exc_busy;
  logic [1:0]  exc_cause;

  int          vectors = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] model_epc = 32'd0;
  logic [1:0]  model_cause = 2'd3;
  logic [7:0]  mem [256];
  logic [7:0]  rd_addr = 8'd0;

  always #5 clk = ~clk;

  // Memory model: address latched while mem_read, upper bits are junk.
  always @(posedge clk) if (mem_read) rd_addr <= mem_addr[7:0];
  assign mem_data_in = {24'hDEADBE, mem[rd_addr]};

  exc_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .eret         (eret),
    .pc_in        (pc_in),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .epc_out      (epc_out),
    .exc_vector   (exc_vector),
    .pc_sel       (pc_sel),
    .pc_write     (pc_write),
    .exc_busy     (exc_busy),
    .exc_cause    (exc_cause)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_exc(input logic o, input logic v, input logic d,
                           input logic [31:0] pc, input exp_t e);
    exc_opcode = o; exc_overflow = v; exc_div0 = d; pc_in = pc;
    sb.push_back(e);
    model_epc = e.epc; model_cause = e.cause;
    tick();
    exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
    vectors++;
    if (epc_out !== e.epc || exc_cause !== e.cause) begin
      errors++;
      $display("FAIL epc_cause_t1: epc=%h cause=%0d want epc=%h cause=%0d",
               epc_out, exc_cause, e.epc, e.cause);
    end
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== e.addr || exc_busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_t1: rd=%b addr=%0d busy=%b want rd=1 addr=%0d busy=1",
               mem_read, mem_addr, exc_busy, e.addr);
    end
  endtask

  task automatic wait_jump(input int exp_ticks);
    int   n;
    exp_t e;
    n = 0;
    while (n < 12) begin
      tick(); n++;
      if (pc_write === 1'b1) break;
    end
    vectors++;
    if (pc_write !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL jump_timeout: pc_write=%b queued=%0d want pc_write=1",
               pc_write, sb.size());
      sb.delete();
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (n !== exp_ticks) begin
      errors++;
      $display("FAIL jump_latency: got %0d cycles want %0d", n, exp_ticks);
    end
    vectors++;
    if (pc_sel !== 3'b101 || exc_vector !== e.vec || exc_busy !== 1'b1) begin
      errors++;
      $display("FAIL jump_out: sel=%b vec=%h busy=%b want sel=101 vec=%h busy=1",
               pc_sel, exc_vector, exc_busy, e.vec);
    end
    vectors++;
    if (epc_out !== e.epc || exc_cause !== e.cause) begin
      errors++;
      $display("FAIL jump_epc: epc=%h cause=%0d want epc=%h cause=%0d",
               epc_out, exc_cause, e.epc, e.cause);
    end
    tick();
    vectors++;
    if (pc_write !== 1'b0 || exc_busy !== 1'b0 || pc_sel !== 3'b000) begin
      errors++;
      $display("FAIL after_jump: pw=%b busy=%b sel=%b want 0 0 000",
               pc_write, exc_busy, pc_sel);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    vectors++;
    if (epc_out !== 32'd0 || exc_vector !== 32'd0 || exc_cause !== 2'd3 ||
        pc_sel !== 3'b000 || pc_write !== 1'b0 || exc_busy !== 1'b0 ||
        mem_read !== 1'b0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL %s: epc=%h vec=%h cause=%0d sel=%b pw=%b busy=%b rd=%b addr=%h want reset values",
               tag, epc_out, exc_vector, exc_cause, pc_sel, pc_write,
               exc_busy, mem_read, mem_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    check_reset_vals("reset");
    reset = 0; tick();
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_overflow();
    drive_exc(0, 1, 0, 32'h104, '{2'd1, 32'h100, 32'd254, 32'h3C});
    tick();
    vectors++;
    if (mem_addr !== 32'd254 || mem_read !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL ovf_t2: addr=%0d rd=%b pw=%b want 254 1 0",
               mem_addr, mem_read, pc_write);
    end
    wait_jump(MEM_LAT);
  endtask

  task automatic test_priority();
    drive_exc(1, 1, 1, 32'h200, '{2'd0, 32'h1FC, 32'd253, 32'h5A});
    wait_jump(MEM_LAT + 1);
  endtask

  task automatic test_eret();
    eret = 1; tick(); eret = 0;
    vectors++;
    if (pc_sel !== 3'b011 || pc_write !== 1'b1 || exc_busy !== 1'b0 ||
        epc_out !== model_epc || exc_cause !== model_cause) begin
      errors++;
      $display("FAIL eret: sel=%b pw=%b busy=%b epc=%h want 011 1 0 %h",
               pc_sel, pc_write, exc_busy, epc_out, model_epc);
    end
    tick();
    vectors++;
    if (pc_write !== 1'b0 || pc_sel !== 3'b000) begin
      errors++;
      $display("FAIL eret_end: pw=%b sel=%b want 0 000", pc_write, pc_sel);
    end
  endtask

  task automatic test_eret_vs_exc();
    eret = 1;
    drive_exc(0, 1, 0, 32'h300, '{2'd1, 32'h2FC, 32'd254, 32'h3C});
    eret = 0;
    vectors++;
    if (pc_write !== 1'b0) begin
      errors++;
      $display("FAIL exc_beats_eret: pw=%b want 0", pc_write);
    end
    wait_jump(MEM_LAT + 1);
  endtask

  task automatic test_ignore_in_fetch();
    int pw;
    drive_exc(1, 0, 0, 32'h1000, '{2'd0, 32'hFFC, 32'd253, 32'h5A});
    exc_overflow = 1; eret = 1; pc_in = 32'h2000;
    tick();
    exc_overflow = 0; eret = 0;
    vectors++;
    if (exc_cause !== 2'd0 || epc_out !== 32'hFFC || mem_addr !== 32'd253) begin
      errors++;
      $display("FAIL ignore_fetch: cause=%0d epc=%h addr=%0d want 0 ffc 253",
               exc_cause, epc_out, mem_addr);
    end
    wait_jump(MEM_LAT);
    pw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pc_write === 1'b1) pw++;
    end
    vectors++;
    if (pw !== 0 || exc_cause !== 2'd0) begin
      errors++;
      $display("FAIL single_jump: extra pc_write=%0d cause=%0d want 0 0",
               pw, exc_cause);
    end
  endtask

  task automatic test_reset_capture();
    int pw;
    drive_exc(0, 1, 0, 32'h40, '{2'd1, 32'h3C, 32'd254, 32'h3C});
    for (int i = 0; i < MEM_LAT; i++) tick();
    vectors++;
    if (exc_busy !== 1'b1 || mem_read !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL capture_state: busy=%b rd=%b pw=%b want 1 0 0",
               exc_busy, mem_read, pc_write);
    end
    reset = 1; tick(); reset = 0;
    check_reset_vals("reset_in_capture");
    sb.delete();
    model_epc = 32'd0; model_cause = 2'd3;
    pw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pc_write === 1'b1) pw++;
    end
    vectors++;
    if (pw !== 0) begin
      errors++;
      $display("FAIL no_jump_after_reset: pc_write cycles=%0d want 0", pw);
    end
    drive_exc(0, 1, 0, 32'h0, '{2'd1, 32'hFFFF_FFFC, 32'd254, 32'h3C});
    wait_jump(MEM_LAT + 1);
  endtask

  task automatic test_div0();
`ifdef EXC_DIV0_EN
    drive_exc(0, 0, 1, 32'h800, '{2'd2, 32'h7FC, 32'd255, 32'h77});
    wait_jump(MEM_LAT + 1);
`else
    int pw;
    exc_div0 = 1; pc_in = 32'h800; tick(); exc_div0 = 0;
    vectors++;
    if (exc_busy !== 1'b0 || mem_read !== 1'b0 ||
        exc_cause !== model_cause || epc_out !== model_epc) begin
      errors++;
      $display("FAIL div0_off: busy=%b rd=%b cause=%0d epc=%h want 0 0 %0d %h",
               exc_busy, mem_read, exc_cause, epc_out, model_cause, model_epc);
    end
    pw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc_write === 1'b1 || exc_busy === 1'b1) pw++;
    end
    vectors++;
    if (pw !== 0) begin
      errors++;
      $display("FAIL div0_idle: active cycles=%0d want 0", pw);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive_exc(1, 0, 0, 32'h10, '{2'd0, 32'hC, 32'd253, 32'h5A});
    wait_jump(MEM_LAT + 1);
    drive_exc(0, 1, 0, 32'h20, '{2'd1, 32'h1C, 32'd254, 32'h3C});
    wait_jump(MEM_LAT + 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[253] = 8'h5A;
    mem[254] = 8'h3C;
    mem[255] = 8'h77;
    tick();
    test_reset();
    test_overflow();
    test_priority();
    test_eret();
    test_eret_vs_exc();
    test_ignore_in_fetch();
    test_reset_capture();
    test_div0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
